// File: rtl/mp_avs_responder.sv
// mp_avs_responder
// Avalon-MM slave responder sitting at the far end of the multipump memory
// port's avm_* master bus. It holds a word-addressed memory, applies
// byte-enabled writes, and returns read data after READ_LATENCY cycles with a
// one-cycle valid strobe. Saturating request counters and a sticky protocol
// error flag are provided for simulation and bring-up.
//
// Optional feature: define MP_AVS_WAITREQ_EN to add avm_waitrequest, which
// stalls every STALL_PERIOD-th request for exactly one cycle.
//
// Ports:
//   clock           2X memory clock, all state on its rising edge
//   resetn          asynchronous active-low reset
//   avm_addr        byte address of the request
//   avm_write_en    write request
//   avm_read_en     read request
//   avm_byte_en     per-byte write enable
//   avm_write_data  write data
//   avm_read_data   read response data (holds last value between strobes)
//   avm_read_valid  one-cycle strobe qualifying avm_read_data
//   wr_count        accepted writes, saturating at 16'hFFFF
//   rd_count        accepted reads, saturating at 16'hFFFF
//   proto_err       sticky, set when write and read are requested together
//   avm_waitrequest (MP_AVS_WAITREQ_EN only) combinational stall
//
// Handshake: a request (write_en or read_en high) is accepted on a rising
// edge when waitrequest is low (always low without MP_AVS_WAITREQ_EN). While
// waitrequest is high the master must hold the request unchanged. Read
// responses carry no backpressure: avm_read_valid pulses for one cycle
// READ_LATENCY edges after the read was accepted.
module mp_avs_responder #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH_LOG2   = 8,
  parameter int READ_LATENCY = 1,
  parameter int STALL_PERIOD = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   avm_addr,
  input  logic                    avm_write_en,
  input  logic                    avm_read_en,
  input  logic [DATA_WIDTH/8-1:0] avm_byte_en,
  input  logic [DATA_WIDTH-1:0]   avm_write_data,
  output logic [DATA_WIDTH-1:0]   avm_read_data,
  output logic                    avm_read_valid,
  output logic [15:0]             wr_count,
  output logic [15:0]             rd_count,
  output logic                    proto_err
`ifdef MP_AVS_WAITREQ_EN
  ,
  output logic                    avm_waitrequest
`endif
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(NBYTES);
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-offset bits are ignored and upper bits wrap, so only a slice of the
  // address selects the word.
  logic [DEPTH_LOG2-1:0] idx;
  assign idx = avm_addr[OFF +: DEPTH_LOG2];

  logic unused_addr;
  assign unused_addr = ^avm_addr;

  logic req;
  logic acc;
  logic acc_wr;
  logic acc_rd;
  logic both_req;

  assign req      = avm_write_en | avm_read_en;
  assign both_req = avm_write_en & avm_read_en;

`ifdef MP_AVS_WAITREQ_EN
  localparam logic [3:0] STALL_LAST = 4'(STALL_PERIOD - 1);

  logic [3:0] stall_cnt;
  logic       prev_stall;

  // prev_stall guarantees the held request is taken on the very next cycle.
  assign avm_waitrequest = req && (stall_cnt == STALL_LAST) && !prev_stall;
  assign acc             = req && !avm_waitrequest;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt  <= 4'd0;
      prev_stall <= 1'b0;
    end else begin
      prev_stall <= avm_waitrequest;
      if (acc) begin
        stall_cnt <= (stall_cnt == STALL_LAST) ? 4'd0 : stall_cnt + 4'd1;
      end
    end
  end
`else
  assign acc = req;
`endif

  // A combined write+read performs only the write.
  assign acc_wr = acc && avm_write_en;
  assign acc_rd = acc && avm_read_en && !both_req;

  // Memory is deliberately not reset.
  always_ff @(posedge clock) begin
    if (acc_wr) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (avm_byte_en[b]) begin
          mem[idx][b*8 +: 8] <= avm_write_data[b*8 +: 8];
        end
      end
    end
  end

  // Read pipeline. Each data stage only loads when the stage before it holds
  // a valid word, so the last stage keeps the most recent response data
  // between strobes.
  logic [READ_LATENCY-1:0] pipe_v;
  logic [DATA_WIDTH-1:0]   pipe_d [READ_LATENCY];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= acc_rd;
      if (acc_rd) begin
        pipe_d[0] <= mem[idx];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

  assign avm_read_valid = pipe_v[READ_LATENCY-1];
  assign avm_read_data  = pipe_d[READ_LATENCY-1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_count  <= 16'd0;
      rd_count  <= 16'd0;
      proto_err <= 1'b0;
    end else begin
      if (acc_wr && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
      if (acc_rd && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
      if (acc && both_req) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mp_avs_responder.sv
// Testbench for mp_avs_responder (default build). Two instances share the
// request bus: one with READ_LATENCY=1, one with READ_LATENCY=3. Expected
// read data and arrival cycle are queued when a read is driven and popped
// when each instance strobes avm_read_valid.
module tb_mp_avs_responder;

  logic        clock;
  logic        resetn;
  logic [63:0] avm_addr;
  logic        avm_write_en;
  logic        avm_read_en;
  logic [7:0]  avm_byte_en;
  logic [63:0] avm_write_data;

  logic [63:0] rd1, rd3;
  logic        v1, v3;
  logic [15:0] wc1, wc3, rc1, rc3;
  logic        pe1, pe3;
`ifdef MP_AVS_WAITREQ_EN
  logic        wreq1, wreq3;
`endif

  mp_avs_responder #(.READ_LATENCY(1)) dut_l1 (
    .clock(clock), .resetn(resetn), .avm_addr(avm_addr),
    .avm_write_en(avm_write_en), .avm_read_en(avm_read_en),
    .avm_byte_en(avm_byte_en), .avm_write_data(avm_write_data),
    .avm_read_data(rd1), .avm_read_valid(v1),
    .wr_count(wc1), .rd_count(rc1), .proto_err(pe1)
`ifdef MP_AVS_WAITREQ_EN
    , .avm_waitrequest(wreq1)
`endif
  );

  mp_avs_responder #(.READ_LATENCY(3)) dut_l3 (
    .clock(clock), .resetn(resetn), .avm_addr(avm_addr),
    .avm_write_en(avm_write_en), .avm_read_en(avm_read_en),
    .avm_byte_en(avm_byte_en), .avm_write_data(avm_write_data),
    .avm_read_data(rd3), .avm_read_valid(v3),
    .wr_count(wc3), .rd_count(rc3), .proto_err(pe3)
`ifdef MP_AVS_WAITREQ_EN
    , .avm_waitrequest(wreq3)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;

  logic [63:0] exp_q1[$];
  logic [63:0] exp_q3[$];
  int          cyc_q1[$];
  int          cyc_q3[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clock) begin : mon_l1
    logic [63:0] d;
    int          c;
    if (resetn && v1) begin
      if (exp_q1.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid_l1: valid=1 with nothing expected (cycle %0d)", cyc);
      end else begin
        d = exp_q1.pop_front();
        c = cyc_q1.pop_front();
        chk("rd_data_l1", rd1, d);
        chk("rd_cycle_l1", 64'(cyc), 64'(c));
      end
    end
  end

  always @(negedge clock) begin : mon_l3
    logic [63:0] d;
    int          c;
    if (resetn && v3) begin
      if (exp_q3.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid_l3: valid=1 with nothing expected (cycle %0d)", cyc);
      end else begin
        d = exp_q3.pop_front();
        c = cyc_q3.pop_front();
        chk("rd_data_l3", rd3, d);
        chk("rd_cycle_l3", 64'(cyc), 64'(c));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic w, input logic r, input logic [63:0] a,
                       input logic [7:0] b, input logic [63:0] d, input logic [63:0] e);
    @(negedge clock);
    avm_write_en   = w;
    avm_read_en    = r;
    avm_addr       = a;
    avm_byte_en    = b;
    avm_write_data = d;
    if (r && !w) begin
      exp_q1.push_back(e);
      cyc_q1.push_back(cyc + 1);
      exp_q3.push_back(e);
      cyc_q3.push_back(cyc + 3);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 64'h0);
  endtask

  task automatic chk_both(input string name, input logic [63:0] a1,
                          input logic [63:0] a3, input logic [63:0] e);
    chk({name, "_l1"}, a1, e);
    chk({name, "_l3"}, a3, e);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        we;
    logic        re;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 64'h7f,  8'hff, 64'h00000000deadbeef, 64'h0};
    tbl[1]  = '{1'b0, 1'b1, 64'h7f,  8'h00, 64'h0,                64'h00000000deadbeef};
    tbl[2]  = '{1'b1, 1'b0, 64'h100, 8'hff, 64'h1111111111111111, 64'h0};
    tbl[3]  = '{1'b1, 1'b0, 64'h100, 8'hf0, 64'hbeefdead00000000, 64'h0};
    tbl[4]  = '{1'b0, 1'b1, 64'h100, 8'h00, 64'h0,                64'hbeefdead11111111};
    tbl[5]  = '{1'b1, 1'b0, 64'h0,   8'hff, 64'h0123456789abcdef, 64'h0};
    tbl[6]  = '{1'b1, 1'b0, 64'h8,   8'hff, 64'h1122334455667788, 64'h0};
    tbl[7]  = '{1'b1, 1'b0, 64'h10,  8'hff, 64'hcafef00d12345678, 64'h0};
    tbl[8]  = '{1'b0, 1'b1, 64'h0,   8'h00, 64'h0,                64'h0123456789abcdef};
    tbl[9]  = '{1'b0, 1'b1, 64'h8,   8'h00, 64'h0,                64'h1122334455667788};
    tbl[10] = '{1'b0, 1'b1, 64'h10,  8'h00, 64'h0,                64'hcafef00d12345678};
    tbl[11] = '{1'b1, 1'b0, 64'h805, 8'h00, 64'hffffffffffffffff, 64'h0};
    tbl[12] = '{1'b0, 1'b1, 64'h800, 8'h00, 64'h0,                64'h0123456789abcdef};
    tbl[13] = '{1'b1, 1'b0, 64'h3,   8'h01, 64'h00000000000000aa, 64'h0};
    tbl[14] = '{1'b0, 1'b1, 64'h7,   8'h00, 64'h0,                64'h0123456789abcdaa};

    resetn         = 1'b0;
    avm_write_en   = 1'b0;
    avm_read_en    = 1'b0;
    avm_addr       = 64'h0;
    avm_byte_en    = 8'h0;
    avm_write_data = 64'h0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    // Reset state after idling.
    idle(10);
    chk_both("reset_valid", 64'(v1), 64'(v3), 64'h0);
    chk_both("reset_wr_count", 64'(wc1), 64'(wc3), 64'h0);
    chk_both("reset_rd_count", 64'(rc1), 64'(rc3), 64'h0);
    chk_both("reset_proto_err", 64'(pe1), 64'(pe3), 64'h0);
    chk_both("reset_rd_data", rd1, rd3, 64'h0);

    // Table: back-to-back writes/reads, byte enables, RAW, aliasing.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].exp);
    end
    idle(6);
    chk_both("wr_count_tbl", 64'(wc1), 64'(wc3), 64'd8);
    chk_both("rd_count_tbl", 64'(rc1), 64'(rc3), 64'd7);
    chk_both("proto_err_tbl", 64'(pe1), 64'(pe3), 64'h0);
    chk_both("rd_data_hold", rd1, rd3, 64'h0123456789abcdaa);
    chk_both("queue_drained", 64'(exp_q1.size()), 64'(exp_q3.size()), 64'h0);

    // Simultaneous write and read: write only, no strobe, sticky error.
    drive(1'b1, 1'b1, 64'h1ff, 8'hff, 64'h5555aaaa5555aaaa, 64'h0);
    idle(5);
    chk_both("proto_err_set", 64'(pe1), 64'(pe3), 64'h1);
    drive(1'b0, 1'b1, 64'h1ff, 8'h00, 64'h0, 64'h5555aaaa5555aaaa);
    idle(6);
    chk_both("wr_count_both", 64'(wc1), 64'(wc3), 64'd9);
    chk_both("rd_count_both", 64'(rc1), 64'(rc3), 64'd8);
    chk_both("proto_err_sticky", 64'(pe1), 64'(pe3), 64'h1);

    // Reset asserted just after a read is accepted drops the response.
    drive(1'b0, 1'b1, 64'h7f, 8'h00, 64'h0, 64'h0);
    @(posedge clock);
    #1;
    resetn      = 1'b0;
    avm_read_en = 1'b0;
    exp_q1.delete(); cyc_q1.delete();
    exp_q3.delete(); cyc_q3.delete();
    #1;
    chk_both("midrst_valid", 64'(v1), 64'(v3), 64'h0);
    chk_both("midrst_rd_data", rd1, rd3, 64'h0);
    chk_both("midrst_proto_err", 64'(pe1), 64'(pe3), 64'h0);
    chk_both("midrst_wr_count", 64'(wc1), 64'(wc3), 64'h0);
    chk_both("midrst_rd_count", 64'(rc1), 64'(rc3), 64'h0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    idle(6);
    chk_both("postrst_valid", 64'(v1), 64'(v3), 64'h0);
    chk_both("postrst_rd_data", rd1, rd3, 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
